// File: rtl/mem_responder_if.sv
// Request/response channel pair of the mem_s transaction: valid/ready request carrying
// addr/data/wr, and valid/ready response carrying addr/data/wr/err.
interface mem_responder_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       req_wr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_addr;
  logic [7:0] rsp_data;
  logic       rsp_wr;
  logic       rsp_err;

  modport master (
    output req_valid, req_addr, req_data, req_wr, rsp_ready,
    input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_wr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_wr, rsp_ready,
    output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_wr, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory transaction responder: one outstanding request, programmable wait states,
// byte-wide memory and saturating completion statistics.
module mem_responder #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  mem_responder_if.slave bus_if,
  output logic           busy_o,
  output logic [15:0]    rd_cnt_o,
  output logic [15:0]    wr_cnt_o,
  output logic [7:0]     err_cnt_o
);

  localparam int unsigned AddrW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        busy_q;
  logic [7:0]  addr_q;
  logic [7:0]  data_q;
  logic        wr_q;
  logic [3:0]  wait_q;
  logic [7:0]  rsp_addr_q;
  logic [7:0]  rsp_data_q;
  logic        rsp_wr_q;
  logic        rsp_err_q;
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;
  logic [7:0]  err_cnt_q;

  logic [7:0]       mem_q [MEM_DEPTH];
  logic             in_range;
  logic             commit;
  logic [AddrW-1:0] idx;
  logic [7:0]       rd_data;

  assign in_range = (32'(addr_q) < MEM_DEPTH);
  assign commit   = (state_q == StAccess) && (wait_q == 4'd0);
  assign idx      = addr_q[AddrW-1:0];
  assign rd_data  = mem_q[idx];

  // Not reset; a commit edge that coincides with reset is discarded.
  always_ff @(posedge clk_i) begin
    if (rst_ni && commit && wr_q && in_range) begin
      mem_q[idx] <= data_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= 8'd0;
      data_q      <= 8'd0;
      wr_q        <= 1'b0;
      wait_q      <= 4'd0;
      rsp_addr_q  <= 8'd0;
      rsp_data_q  <= 8'd0;
      rsp_wr_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_cnt_q    <= 16'd0;
      wr_cnt_q    <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_if.req_valid) begin
            addr_q      <= bus_if.req_addr;
            data_q      <= bus_if.req_data;
            wr_q        <= bus_if.req_wr;
            wait_q      <= 4'(WAIT_CYCLES);
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else begin
            rsp_addr_q  <= addr_q;
            rsp_wr_q    <= wr_q;
            rsp_err_q   <= ~in_range;
            rsp_data_q  <= !in_range ? 8'd0 : (wr_q ? data_q : rd_data);
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (bus_if.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
            if (rsp_err_q) begin
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end else if (rsp_wr_q) begin
              if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
              if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_if.req_ready = req_ready_q;
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_addr  = rsp_addr_q;
  assign bus_if.rsp_data  = rsp_data_q;
  assign bus_if.rsp_wr    = rsp_wr_q;
  assign bus_if.rsp_err   = rsp_err_q;
  assign busy_o           = busy_q;
  assign rd_cnt_o         = rd_cnt_q;
  assign wr_cnt_o         = wr_cnt_q;
  assign err_cnt_o        = err_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three configurations share one driver, selected by sel, and
// are checked against a transaction-level model of memory contents and counters.
module tb_mem_responder;

  localparam int unsigned DepthC [3] = '{256, 16, 256};
  localparam int unsigned WaitC  [3] = '{0, 4, 3};

  logic       clk = 1'b0;
  logic       rst_n;
  int         sel;
  logic       req_valid;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_ready;

  logic        o_rdy  [3];
  logic        o_rvld [3];
  logic [7:0]  o_raddr[3];
  logic [7:0]  o_rdata[3];
  logic        o_rwr  [3];
  logic        o_rerr [3];
  logic        o_busy [3];
  logic [15:0] o_rcnt [3];
  logic [15:0] o_wcnt [3];
  logic [7:0]  o_ecnt [3];

  logic [7:0] mdl_mem [3][256];
  bit         mdl_vld [3][256];
  int         mdl_rd  [3];
  int         mdl_wr  [3];
  int         mdl_err [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_responder_if if0 ();
  mem_responder_if if1 ();
  mem_responder_if if2 ();

  assign if0.req_valid = req_valid && (sel == 0);
  assign if1.req_valid = req_valid && (sel == 1);
  assign if2.req_valid = req_valid && (sel == 2);
  assign if0.req_addr = req_addr;  assign if1.req_addr = req_addr;  assign if2.req_addr = req_addr;
  assign if0.req_data = req_data;  assign if1.req_data = req_data;  assign if2.req_data = req_data;
  assign if0.req_wr = req_wr;      assign if1.req_wr = req_wr;      assign if2.req_wr = req_wr;
  assign if0.rsp_ready = rsp_ready; assign if1.rsp_ready = rsp_ready; assign if2.rsp_ready = rsp_ready;

  assign o_rdy[0] = if0.req_ready;   assign o_rdy[1] = if1.req_ready;   assign o_rdy[2] = if2.req_ready;
  assign o_rvld[0] = if0.rsp_valid;  assign o_rvld[1] = if1.rsp_valid;  assign o_rvld[2] = if2.rsp_valid;
  assign o_raddr[0] = if0.rsp_addr;  assign o_raddr[1] = if1.rsp_addr;  assign o_raddr[2] = if2.rsp_addr;
  assign o_rdata[0] = if0.rsp_data;  assign o_rdata[1] = if1.rsp_data;  assign o_rdata[2] = if2.rsp_data;
  assign o_rwr[0] = if0.rsp_wr;      assign o_rwr[1] = if1.rsp_wr;      assign o_rwr[2] = if2.rsp_wr;
  assign o_rerr[0] = if0.rsp_err;    assign o_rerr[1] = if1.rsp_err;    assign o_rerr[2] = if2.rsp_err;

  mem_responder #(.MEM_DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus_if(if0), .busy_o(o_busy[0]),
    .rd_cnt_o(o_rcnt[0]), .wr_cnt_o(o_wcnt[0]), .err_cnt_o(o_ecnt[0])
  );
  mem_responder #(.MEM_DEPTH(16), .WAIT_CYCLES(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus_if(if1), .busy_o(o_busy[1]),
    .rd_cnt_o(o_rcnt[1]), .wr_cnt_o(o_wcnt[1]), .err_cnt_o(o_ecnt[1])
  );
  mem_responder #(.MEM_DEPTH(256), .WAIT_CYCLES(3)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus_if(if2), .busy_o(o_busy[2]),
    .rd_cnt_o(o_rcnt[2]), .wr_cnt_o(o_wcnt[2]), .err_cnt_o(o_ecnt[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (inst %0d): got 0x%0h expected 0x%0h", tag, sel, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hs"}, {o_rdy[sel], o_rvld[sel], o_busy[sel]}, 3'b100);
    check({tag, "_rsp"}, {o_raddr[sel], o_rdata[sel], o_rwr[sel], o_rerr[sel]}, 18'd0);
    check({tag, "_cnt"}, {o_rcnt[sel], o_wcnt[sel]}, 32'd0);
    check({tag, "_ecnt"}, o_ecnt[sel], 8'd0);
  endtask

  // One complete transaction on instance sel; called one time unit after a clock edge while idle.
  task automatic do_txn(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                        input int stall, input bit hold);
    int         cyc;
    bit         bad;
    bit         in_rng;
    bit         known;
    logic [7:0] exp_data;
    logic [17:0] snap;
    in_rng = (32'(addr) < DepthC[sel]);
    known  = 1'b1;
    if (!in_rng)  exp_data = 8'd0;
    else if (wr)  exp_data = data;
    else begin
      exp_data = mdl_mem[sel][addr];
      known    = mdl_vld[sel][addr];
    end
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_data = data;
    rsp_ready = (stall == 0);
    check("idle_ready", {o_rdy[sel], o_busy[sel]}, 2'b10);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    cyc = 0; bad = 1'b0;
    while (!o_rvld[sel] && cyc < 64) begin
      if (!o_busy[sel] || o_rdy[sel]) bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, 1 + WaitC[sel]);
    check("busy_access", bad, 1'b0);
    check("rsp_addr", o_raddr[sel], addr);
    check("rsp_wr_err", {o_rwr[sel], o_rerr[sel]}, {wr, ~in_rng});
    if (known) check("rsp_data", o_rdata[sel], exp_data);
    if (in_rng && wr) begin
      mdl_mem[sel][addr] = data;
      mdl_vld[sel][addr] = 1'b1;
    end
    snap = {o_raddr[sel], o_rdata[sel], o_rwr[sel], o_rerr[sel]};
    bad  = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (!o_rvld[sel] || o_rdy[sel] || !o_busy[sel]) bad = 1'b1;
      if ({o_raddr[sel], o_rdata[sel], o_rwr[sel], o_rerr[sel]} != snap) bad = 1'b1;
    end
    if (stall > 0) check("stall_stable", bad, 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_done", {o_rvld[sel], o_rdy[sel], o_busy[sel]}, 3'b010);
    if (!in_rng)  mdl_err[sel] = (mdl_err[sel] < 255) ? mdl_err[sel] + 1 : 255;
    else if (wr)  mdl_wr[sel]  = (mdl_wr[sel] < 65535) ? mdl_wr[sel] + 1 : 65535;
    else          mdl_rd[sel]  = (mdl_rd[sel] < 65535) ? mdl_rd[sel] + 1 : 65535;
    check("rd_cnt", o_rcnt[sel], mdl_rd[sel]);
    check("wr_cnt", o_wcnt[sel], mdl_wr[sel]);
    check("err_cnt", o_ecnt[sel], mdl_err[sel]);
  endtask

  task automatic clear_counters();
    for (int s = 0; s < 3; s++) begin
      mdl_rd[s] = 0; mdl_wr[s] = 0; mdl_err[s] = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    logic       w;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 256; i++) mdl_vld[s][i] = 1'b0;
    clear_counters();
    sel = 0; rst_n = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'd0; req_data = 8'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check_reset("reset");
    end
    rst_n = 1'b1;
    sel = 0;
    @(posedge clk); #1;

    // Basic write then read with no wait states.
    do_txn(1'b1, 8'h10, 8'h5A, 0, 1'b0);
    do_txn(1'b0, 8'h10, 8'h00, 0, 1'b0);
    check("basic_rd", o_rdata[0], 8'h5A);
    check("basic_cnts", {o_wcnt[0], o_rcnt[0]}, {16'd1, 16'd1});

    // Backpressure with req_valid held high, then a back-to-back request.
    do_txn(1'b1, 8'h44, 8'hC3, 10, 1'b1);
    do_txn(1'b0, 8'h44, 8'h00, 0, 1'b0);

    // Three wait states.
    sel = 2; #1;
    do_txn(1'b1, 8'h80, 8'h96, 0, 1'b0);
    do_txn(1'b0, 8'h80, 8'h00, 2, 1'b0);

    // Reset during ACCESS of a write must discard it.
    sel = 1; #1;
    do_txn(1'b1, 8'h05, 8'h11, 0, 1'b0);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h05; req_data = 8'h33;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", o_busy[1], 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_counters();
    check_reset("mid_reset");
    do_txn(1'b0, 8'h05, 8'h00, 0, 1'b0);
    check("after_reset_rd", o_rdata[1], 8'h11);

    // Out-of-range write on the 16-deep instance must not alias onto address 0.
    do_txn(1'b1, 8'h00, 8'hAB, 0, 1'b0);
    do_txn(1'b1, 8'h20, 8'hFF, 1, 1'b0);
    check("oor_err_cnt", o_ecnt[1], 8'd1);
    do_txn(1'b0, 8'h00, 8'h00, 0, 1'b0);
    check("no_alias", o_rdata[1], 8'hAB);

    // Randomized traffic on every configuration.
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      for (int n = 0; n < 40; n++) begin
        a = (s == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
        w = 1'($urandom_range(0, 1));
        if (!w && (32'(a) < DepthC[s]) && !mdl_vld[s][a]) w = 1'b1;
        do_txn(w, a, 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
    end
    req_valid = 1'b0;

    // Saturation: preload the read counter near its limit.
    sel = 0; #1;
    force u_dut0.rd_cnt_q = 16'hFFFD;
    @(posedge clk); #1;
    release u_dut0.rd_cnt_q;
    mdl_rd[0] = 32'hFFFD;
    repeat (4) do_txn(1'b0, 8'h10, 8'h00, 0, 1'b0);
    check("rd_sat", o_rcnt[0], 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Target side of the team's `mem_s` memory transaction (8-bit `addr`, 8-bit `data`, `wr` flag). Accepts one request at a time over a valid/ready channel, performs the write or read against an internal byte-wide memory after a programmable wait-state count, and returns exactly one response per request over a second valid/ready channel. It is the responder that the team's transaction initiators and testbench drivers connect to, and it also maintains saturating read/write/error statistics.

## Interface
- `MEM_DEPTH`, 256: number of implemented byte locations (1..256); addresses ≥ MEM_DEPTH are out of range.
- `WAIT_CYCLES`, 0: extra access wait states (0..15).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_addr` in 8: request `addr` field.
- `req_data` in 8: request `data` field (write data; ignored for reads).
- `req_wr` in 1: request `wr` field; 1 = write, 0 = read.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_addr` out 8: echoed request address.
- `rsp_data` out 8: read data for reads; echoed write data for writes; 0 on error.
- `rsp_wr` out 1: echoed `wr` field.
- `rsp_err` out 1: address out of range.
- `busy` out 1: high whenever the state is not IDLE.
- `rd_cnt` out 16: number of completed good reads, saturating.
- `wr_cnt` out 16: number of completed good writes, saturating.
- `err_cnt` out 8: number of completed error responses, saturating.

## Operation
- FSM states: IDLE, ACCESS, RESP. Only one transaction is outstanding at a time.
- IDLE: `req_ready`=1. A request is accepted on the edge where `req_valid && req_ready`.
  - On acceptance, register addr/data/wr.
  - Load the wait counter with WAIT_CYCLES.
  - Go to ACCESS.
- ACCESS: `req_ready`=0.
  - While the counter ≠ 0, decrement it by 1 per cycle.
  - On the edge where the counter = 0, commit the access and go to RESP.
- Commit of an in-range write: `mem[addr] <= data`; `rsp_data` = data.
- Commit of an in-range read: `rsp_data` = `mem[addr]`, the value at the commit edge.
- Commit of an out-of-range request: no memory change; `rsp_data`=0; `rsp_err`=1.
- In every commit, `rsp_addr`/`rsp_wr` are the registered request fields.
- RESP: `rsp_valid`=1.
  - All `rsp_*` outputs are held stable until the edge where `rsp_valid && rsp_ready`.
  - On that edge, go to IDLE and update exactly one counter: `err_cnt` if `rsp_err`, else `wr_cnt` if `rsp_wr`, else `rd_cnt`.
- Counters saturate: `rd_cnt`/`wr_cnt` hold at 0xFFFF and `err_cnt` at 0xFF; they never wrap.
- Ordering: the single outstanding transaction guarantees read-after-write returns the new value.
- The memory array is not cleared by reset.
  - Contents are undefined until written.
  - Benches must write before reading.

## Timing
- Reset (`rst_n`=0 sampled at an edge) produces:
  - state IDLE; `req_ready`=1, `rsp_valid`=0, `busy`=0;
  - `rsp_addr`/`rsp_data`/`rsp_wr`/`rsp_err`=0;
  - all counters 0.
- Reset mid-transaction:
  - A write that has not reached its commit edge is discarded.
  - A write already committed stays in memory.
  - A pending response is dropped and no counter is updated.
- Latency: request accepted at edge N ⇒ commit at edge N+1+WAIT_CYCLES ⇒ `rsp_valid` high from the cycle after that edge.
  - With WAIT_CYCLES=0, `rsp_valid` rises one cycle after acceptance.
- If `rsp_ready` is already 1 when `rsp_valid` rises, the response completes on the next edge.
  - `req_ready` returns to 1 in the following cycle.
  - Maximum throughput: one transaction per WAIT_CYCLES+3 cycles.
- `req_ready` is a registered state decode and never depends combinationally on `req_valid`.
- `rsp_valid` does not depend combinationally on `rsp_ready`.
- `req_valid` is ignored outside IDLE, with no buffering.
- `rsp_ready` is ignored outside RESP.
- `busy` = (state ≠ IDLE), registered with the state.

## Test plan
- Reset, then write 0x5A to addr 0x10, then read 0x10 (WAIT_CYCLES=0, `rsp_ready` tied 1):
  - Write response has `rsp_data`=0x5A, `rsp_wr`=1, `rsp_err`=0.
  - Read response has `rsp_data`=0x5A, `rsp_wr`=0.
  - Each response is valid one cycle after acceptance.
  - Counters end at `wr_cnt`=1, `rd_cnt`=1.
- WAIT_CYCLES=3; read accepted at edge N: `rsp_valid` rises after edge N+4 and `busy` is high for 4 cycles before RESP.
- Backpressure: hold `rsp_ready`=0 for 10 cycles with `req_valid` held high.
  - `rsp_*` stay stable; `req_ready` stays 0; no second request is accepted.
  - On `rsp_ready`=1, exactly one handshake occurs, then the next request is accepted.
- MEM_DEPTH=16; write 0xFF to addr 0x20, then read addr 0x00:
  - The write response has `rsp_err`=1, `rsp_data`=0, and `err_cnt`=1.
  - The read of 0x00 returns its previously written value, proving no aliasing.
- Assert reset in ACCESS of a write of 0x33 to addr 0x05 (WAIT_CYCLES=4), after a prior write of 0x11 to that address:
  - Outputs return to reset values and all counters are 0.
  - A subsequent read of 0x05 returns the prior value 0x11.
- Counter saturation: force 65,537 good reads (or preload via bench acceleration): `rd_cnt` holds at 0xFFFF.
